adsr_envelope: RTL and testbench
================================

// Module: adsr_envelope
// PURPOSE
//  Attack-decay-sustain-release amplitude envelope for the synth voice path.
//  Scales each incoming signed 16-bit audio sample by a Q1.15 gain.
//  The gain follows a self-retriggering ADSR contour, advanced once per input-sample strobe.
//  Sits between the tone generator and the DAC/codec output stage.
// PARAMETERS
//  ATTACK_STEP      16'd2048  gain increment per strobe in ATTACK (Q1.15, nonzero)
//  DECAY_STEP       16'd1024  gain decrement per strobe in DECAY (nonzero)
//  SUSTAIN_LEVEL    16'h4000  sustain gain (Q1.15, 0 < level <= 16'h8000)
//  SUSTAIN_SAMPLES  16'd32    strobes spent in SUSTAIN (>= 1)
//  RELEASE_STEP     16'd512   gain decrement per strobe in RELEASE (nonzero)
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  reset          in   1   asynchronous, active-high reset
//  pre_sample_in  in   16  signed audio sample, valid when in_ready=1
//  in_ready       in   1   sample strobe; each high clock = one sample
//  sample_out     out  16  signed enveloped sample, registered
// BEHAVIOUR
//  - Reset (async, dominates everything):
//    - state=ATTACK, gain=0, sustain counter=0, sample_out=0.
//  - All state/gain/output updates occur only on clocks with in_ready=1; otherwise everything holds.
//  - On a strobe, sample_out <= (pre_sample_in * $signed({1'b0,gain})) >>> 15.
//    - Uses the gain value BEFORE this strobe's update.
//    - Arithmetic shift (floor); full 33-bit product, then truncate to 16 bits.
//    - The gain never exceeds 16'h8000, so no overflow occurs.
//  - Latency: sample_out is valid on the clock after the strobe and holds until the next strobe.
//  - Gain is 16-bit unsigned Q1.15, range 0..16'h8000 (1.0).
//  - FSM, evaluated per strobe:
//    - ATTACK:  gain <= min(gain+ATTACK_STEP, 16'h8000); when the new gain = 16'h8000 -> DECAY.
//    - DECAY:   gain <= max(gain-DECAY_STEP, SUSTAIN_LEVEL); when the new gain = SUSTAIN_LEVEL -> SUSTAIN, counter <= 0.
//    - SUSTAIN: gain held; counter++; when counter = SUSTAIN_SAMPLES-1 -> RELEASE.
//    - RELEASE: gain <= max(gain-RELEASE_STEP, 0); when the new gain = 0 -> ATTACK (auto-retrigger).
//  - Saturating add/sub: compute in 17 bits and clamp; no wrap-around ever.
//  - If SUSTAIN_LEVEL = 16'h8000, DECAY lasts exactly one strobe.
//  - in_ready held high for N clocks counts as N strobes.
//  - Reset asserted mid-envelope restarts from ATTACK with gain 0 on the first strobe after release.
//  - With defaults, one envelope cycle = 96 strobes:
//    - ATTACK  16 strobes
//    - DECAY   16 strobes
//    - SUSTAIN 32 strobes
//    - RELEASE 32 strobes
// TESTING
//  (stimulus: in_ready 1-clk pulse every 100 clks, pre_sample_in=16'h7FFF on strobes, 0 otherwise)
//  1. Reset: assert reset async mid-cycle -> sample_out=0 immediately; first strobe after release outputs 0.
//  2. Attack ramp: strobe n=1..17 -> sample_out = floor(32767*2048*(n-1)/32768).
//     - n=1:0, n=2:2047, n=17:32767.
//  3. Decay/sustain: strobe 18 -> 31743.
//     - Strobes 33..65 -> 16383 (gain 16'h4000).
//  4. Release/retrigger: strobe 66 -> 15871; strobe 96 -> 511; strobe 97 -> 0; strobe 98 -> 2047.
//  5. Idle hold: no strobes for 1000 clks -> sample_out and gain unchanged.
//     - Sample with pre_sample_in=16'h8000 at gain 16'h8000 -> -32768.
//  6. Back-to-back: in_ready high 3 consecutive clks during ATTACK -> gain advances 3 steps, outputs 0, 2047, 4095.

Source files
------------

// File: rtl/adsr_envelope_if.sv
// Sample stream between the tone generator and the envelope stage.
// The master drives samples and strobes; the slave returns the enveloped sample.
interface adsr_envelope_if;
  logic [15:0] pre_sample_in;
  logic        in_ready;
  logic [15:0] sample_out;

  modport master (output pre_sample_in, output in_ready, input sample_out);
  modport slave  (input pre_sample_in, input in_ready, output sample_out);
endinterface

// File: rtl/adsr_envelope.sv
// Self-retriggering ADSR amplitude envelope.
// The Q1.15 gain advances once per sample strobe and scales each signed 16-bit sample.
module adsr_envelope #(
  parameter logic [15:0] ATTACK_STEP     = 16'd2048,
  parameter logic [15:0] DECAY_STEP      = 16'd1024,
  parameter logic [15:0] SUSTAIN_LEVEL   = 16'h4000,
  parameter logic [15:0] SUSTAIN_SAMPLES = 16'd32,
  parameter logic [15:0] RELEASE_STEP    = 16'd512
) (
  input logic           clk,
  input logic           reset,
  adsr_envelope_if.slave bus
);

  localparam logic [15:0] GAIN_MAX = 16'h8000;

  typedef enum logic [1:0] {
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t             state;
  logic [15:0]        gain;
  logic [15:0]        sus_cnt;
  logic [15:0]        out_q;

  logic signed [32:0] product;
  logic [16:0]        att_sum;
  logic [16:0]        dec_diff;
  logic [16:0]        rel_diff;
  logic [15:0]        att_next;
  logic [15:0]        dec_next;
  logic [15:0]        rel_next;

  // Product uses the gain held before this strobe's update.
  always_comb begin
    product = $signed(bus.pre_sample_in) * $signed({1'b0, gain});
  end

  // 17-bit sums/differences; bit 16 flags carry or borrow so every step clamps.
  always_comb begin
    att_sum  = {1'b0, gain} + {1'b0, ATTACK_STEP};
    dec_diff = {1'b0, gain} - {1'b0, DECAY_STEP};
    rel_diff = {1'b0, gain} - {1'b0, RELEASE_STEP};

    att_next = (att_sum >= {1'b0, GAIN_MAX}) ? GAIN_MAX : att_sum[15:0];

    if (dec_diff[16] || (dec_diff[15:0] <= SUSTAIN_LEVEL))
      dec_next = SUSTAIN_LEVEL;
    else
      dec_next = dec_diff[15:0];

    if (rel_diff[16] || (rel_diff[15:0] == '0))
      rel_next = '0;
    else
      rel_next = rel_diff[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ATTACK;
      gain    <= '0;
      sus_cnt <= '0;
      out_q   <= '0;
    end else if (bus.in_ready) begin
      out_q <= 16'(product >>> 15);
      case (state)
        ATTACK: begin
          gain <= att_next;
          if (att_next == GAIN_MAX) state <= DECAY;
        end
        DECAY: begin
          gain <= dec_next;
          if (dec_next == SUSTAIN_LEVEL) begin
            state   <= SUSTAIN;
            sus_cnt <= '0;
          end
        end
        SUSTAIN: begin
          sus_cnt <= sus_cnt + 16'd1;
          if (sus_cnt == SUSTAIN_SAMPLES - 16'd1) state <= RELEASE;
        end
        RELEASE: begin
          gain <= rel_next;
          if (rel_next == '0) state <= ATTACK;
        end
        default: state <= ATTACK;
      endcase
    end
  end

  assign bus.sample_out = out_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed check of the ADSR envelope: ramp checkpoints, idle hold, full-scale
// negative sample, asynchronous reset and back-to-back strobes.
module tb_adsr_envelope;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  adsr_envelope_if bus ();

  adsr_envelope #(
    .ATTACK_STEP     (16'd2048),
    .DECAY_STEP      (16'd1024),
    .SUSTAIN_LEVEL   (16'h4000),
    .SUSTAIN_SAMPLES (16'd32),
    .RELEASE_STEP    (16'd512)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] sample;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%04h) expected %0d (0x%04h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // One-clock strobe after an idle gap; inputs return to zero afterwards.
  task automatic strobe(input logic [15:0] sample);
    repeat (99) @(negedge clk);
    bus.pre_sample_in = sample;
    bus.in_ready      = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.pre_sample_in = '0;
    bus.in_ready      = 1'b0;
  endtask

  initial begin
    int done;
    logic [15:0] held;

    total = 0;
    bad   = 0;
    bus.pre_sample_in = '0;
    bus.in_ready      = 1'b0;
    reset             = 1'b1;

    vecs.push_back('{n: 1,  sample: 16'h7FFF, exp: 16'd0});
    vecs.push_back('{n: 2,  sample: 16'h7FFF, exp: 16'd2047});
    vecs.push_back('{n: 3,  sample: 16'h7FFF, exp: 16'd4095});
    vecs.push_back('{n: 16, sample: 16'h7FFF, exp: 16'd30719});
    vecs.push_back('{n: 17, sample: 16'h7FFF, exp: 16'd32767});
    vecs.push_back('{n: 18, sample: 16'h7FFF, exp: 16'd31743});
    vecs.push_back('{n: 32, sample: 16'h7FFF, exp: 16'd17407});
    vecs.push_back('{n: 33, sample: 16'h7FFF, exp: 16'd16383});
    vecs.push_back('{n: 50, sample: 16'h7FFF, exp: 16'd16383});
    vecs.push_back('{n: 64, sample: 16'h7FFF, exp: 16'd16383});
    vecs.push_back('{n: 65, sample: 16'h7FFF, exp: 16'd16383});
    vecs.push_back('{n: 66, sample: 16'h7FFF, exp: 16'd15871});
    vecs.push_back('{n: 96, sample: 16'h7FFF, exp: 16'd511});
    vecs.push_back('{n: 97, sample: 16'h7FFF, exp: 16'd0});
    vecs.push_back('{n: 98, sample: 16'h7FFF, exp: 16'd2047});

    repeat (3) @(negedge clk);
    check("reset_out", bus.sample_out, 16'd0);
    reset = 1'b0;

    done = 0;
    foreach (vecs[i]) begin
      while (done < vecs[i].n - 1) begin
        strobe(16'h7FFF);
        done++;
      end
      strobe(vecs[i].sample);
      done++;
      check($sformatf("strobe_%0d", vecs[i].n), bus.sample_out, vecs[i].exp);
    end

    // Long idle stretch: output and gain must both hold (gain 4096 expected next).
    repeat (1000) @(negedge clk);
    check("idle_hold_out", bus.sample_out, 16'd2047);
    strobe(16'h7FFF);
    check("idle_hold_gain", bus.sample_out, 16'd4095);
    done++;

    // Run to strobe 113 of the sequence, where the gain before the strobe is 1.0.
    while (done < 112) begin
      strobe(16'h7FFF);
      done++;
    end
    strobe(16'h8000);
    check("neg_full_scale", bus.sample_out, 16'h8000);

    // Asynchronous reset between clock edges clears the output at once.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", bus.sample_out, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three consecutive strobes from a freshly reset envelope.
    repeat (5) @(negedge clk);
    bus.pre_sample_in = 16'h7FFF;
    bus.in_ready      = 1'b1;
    @(posedge clk); #1 check("b2b_0", bus.sample_out, 16'd0);
    @(posedge clk); #1 check("b2b_1", bus.sample_out, 16'd2047);
    @(posedge clk); #1 check("b2b_2", bus.sample_out, 16'd4095);
    @(negedge clk);
    bus.pre_sample_in = '0;
    bus.in_ready      = 1'b0;
    held = 16'd4095;
    repeat (20) @(negedge clk);
    check("b2b_hold", bus.sample_out, held);
    strobe(16'h7FFF);
    check("b2b_gain", bus.sample_out, 16'd6143);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
